// File: rtl/usb_fs_in_fifo_ep.sv
// Bulk IN endpoint buffer: byte FIFO from the application, packetized into MAX_PKT chunks for the FS engine.
// Optional zero-length packet after a full-size flushed packet: define USB_IN_EP_ZLP_EN.
module usb_fs_in_fifo_ep #(
    parameter int MAX_PKT = 64,
    parameter int FIFO_AW = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         app_data,
    input  logic               app_valid,
    output logic               app_ready,
    input  logic               app_flush,
    input  logic               app_stall,
    output logic               in_ep_req,
    input  logic               in_ep_grant,
    input  logic               in_ep_data_free,
    output logic               in_ep_data_put,
    output logic [7:0]         in_ep_data,
    output logic               in_ep_data_done,
    output logic               in_ep_stall,
    input  logic               in_ep_acked,
    output logic [FIFO_AW:0]   fifo_count
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW+1)'(DEPTH);
    localparam logic [FIFO_AW:0] MAX_C   = (FIFO_AW+1)'(MAX_PKT);
    localparam logic [6:0]       MAX_L   = 7'(MAX_PKT);

    typedef enum logic [2:0] {IDLE, REQ, PUT, DONE, WAIT_ACK} state_t;
    state_t state, state_nxt;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count;
    logic [6:0]         pkt_len, sent, len_nxt;
    logic               flush_pend, last_full;
    logic               wr_en, start, flush_clr;

    assign app_ready   = (count != DEPTH_C);
    assign wr_en       = app_valid && app_ready;
    assign in_ep_data  = mem[rd_ptr];
    assign in_ep_stall = app_stall;
    assign fifo_count  = count;
    assign len_nxt     = (count >= MAX_C) ? MAX_L : 7'(count);

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= app_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en)          wr_ptr <= wr_ptr + 1'b1;
            if (in_ep_data_put) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, in_ep_data_put})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            pkt_len    <= '0;
            sent       <= '0;
            flush_pend <= 1'b0;
            last_full  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start) begin
                pkt_len <= len_nxt;
                sent    <= '0;
            end else if (in_ep_data_put) begin
                sent <= sent + 1'b1;
            end
            // a new flush request outranks a same-cycle clear
            if (app_flush)      flush_pend <= 1'b1;
            else if (flush_clr) flush_pend <= 1'b0;
            if (state == DONE)  last_full  <= (pkt_len == MAX_L);
        end
    end

    always_comb begin
        state_nxt       = state;
        in_ep_req       = 1'b0;
        in_ep_data_put  = 1'b0;
        in_ep_data_done = 1'b0;
        start           = 1'b0;
        flush_clr       = 1'b0;
        case (state)
            IDLE: begin
                if (!app_stall && (count >= MAX_C || (flush_pend && count != '0))) begin
                    start     = 1'b1;
                    state_nxt = REQ;
                end
`ifdef USB_IN_EP_ZLP_EN
                // empty FIFO here, so len_nxt is 0 and a zero-length packet goes out
                else if (!app_stall && flush_pend && last_full) begin
                    start     = 1'b1;
                    state_nxt = REQ;
                end else if (flush_pend && count == '0 && !last_full) begin
                    flush_clr = 1'b1;
                end
`else
                else if (flush_pend && count == '0) begin
                    flush_clr = 1'b1;
                end
`endif
            end
            REQ: begin
                in_ep_req = 1'b1;
                if (in_ep_grant) state_nxt = PUT;
            end
            PUT: begin
                in_ep_req      = 1'b1;
                in_ep_data_put = in_ep_grant && in_ep_data_free && (sent != pkt_len);
                // leave on the last put so the done pulse follows immediately
                if ((sent + 7'(in_ep_data_put)) == pkt_len) state_nxt = DONE;
            end
            DONE: begin
                in_ep_req       = 1'b1;
                in_ep_data_done = 1'b1;
                state_nxt       = WAIT_ACK;
                if (pkt_len != MAX_L) flush_clr = 1'b1;
            end
            WAIT_ACK: begin
                if (in_ep_acked) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: doc/usb_fs_in_fifo_ep.md
# usb_fs_in_fifo_ep

Bulk IN endpoint buffer that sits directly upstream of the full-speed protocol engine's IN endpoint port. It accepts a byte stream from application logic through a valid/ready handshake and stores it in a local FIFO. It packetizes the stream into packets of at most `MAX_PKT` bytes, wins the IN arbiter, and copies each packet into the engine's IN buffer. It does not start the next packet until the host has acknowledged the current one.

## Interface
- `MAX_PKT`, 64: maximum packet payload in bytes; legal range 1..64; must not exceed 2**`FIFO_AW`.
- `FIFO_AW`, 7: FIFO address width; the FIFO depth is 2**`FIFO_AW` bytes.
- `clk`  in  1  single clock for all logic; 48 MHz.
- `reset`  in  1  asynchronous, active-low reset.
- `app_data`  in  8  application byte.
- `app_valid`  in  1  `app_data` is valid.
- `app_ready`  out  1  FIFO can accept a byte; equals (count != depth).
- `app_flush`  in  1  one-cycle pulse requesting that buffered data be sent even if short.
- `app_stall`  in  1  endpoint halt request; passed through to `in_ep_stall`.
- `in_ep_req`  out  1  request for the IN arbiter.
- `in_ep_grant`  in  1  arbiter grant.
- `in_ep_data_free`  in  1  engine buffer can take a byte.
- `in_ep_data_put`  out  1  byte write strobe to the engine.
- `in_ep_data`  out  8  byte to the engine; the current FIFO head.
- `in_ep_data_done`  out  1  one-cycle pulse: the packet is fully loaded.
- `in_ep_stall`  out  1  equals `app_stall`.
- `in_ep_acked`  in  1  one-cycle pulse: the host ACKed the packet.
- `fifo_count`  out  FIFO_AW+1  current FIFO occupancy.

## Operation
- The FIFO is a register array with read pointer and write pointer of `FIFO_AW` bits each, wrapping modulo the depth. The count is `FIFO_AW`+1 bits.
- A write occurs when `app_valid && app_ready`. A read occurs when `in_ep_data_put` is high. A simultaneous write and read leaves the count unchanged. Writes are ignored when the FIFO is full.
- `flush_pend` is set by `app_flush`. It is cleared when a packet shorter than `MAX_PKT` is committed, or per the rules in Configuration. A flush pulse that arrives in the same cycle as a clear wins: `flush_pend` remains set.
- State machine:
  - IDLE → REQ when count >= `MAX_PKT`, or when `flush_pend` && count > 0. On this transition, latch `pkt_len` = min(count, `MAX_PKT`) into a 7-bit register and clear `sent`.
  - REQ: `in_ep_req` = 1. Go to PUT when `in_ep_grant` is high.
  - PUT: `in_ep_req` = 1. `in_ep_data_put` = `in_ep_grant` && `in_ep_data_free` && (`sent` != `pkt_len`). This term is combinational. `sent` increments on each put. When `sent` == `pkt_len`, go to DONE. If `in_ep_data_free` drops, putting pauses and resumes when it returns.
  - DONE: `in_ep_data_done` = 1 for exactly one cycle, with `in_ep_req` still 1. Go to WAIT_ACK. If `pkt_len` < `MAX_PKT`, clear `flush_pend`.
  - WAIT_ACK: `in_ep_req` = 0. Go to IDLE on `in_ep_acked`. Retransmission after NAK or timeout is handled by the engine; this block does nothing.
- Bytes written during PUT are not added to the current packet, because `pkt_len` is already latched.
- While `app_stall` is high, state does not advance out of IDLE. The FIFO keeps accepting data.

## Timing
- Reset values: state = IDLE; pointers, count, `sent`, `pkt_len` and `flush_pend` = 0; `in_ep_req` = 0; `in_ep_data_put` = 0; `in_ep_data_done` = 0; `app_ready` = 1.
- `in_ep_data` is the FIFO head, presented combinationally, and is valid in any cycle that `in_ep_data_put` is high.
- With grant and `in_ep_data_free` held high: REQ is entered the cycle after the trigger; the first put occurs in the cycle after the grant; N bytes take N consecutive cycles; the done pulse follows in the next cycle.
- A written byte appears in `fifo_count` in the next cycle.
- Reset asserted mid-packet aborts immediately. The engine's partial buffer is discarded by the engine's own reset.

## Configuration
- `USB_IN_EP_ZLP_EN` defined:
  - If `flush_pend` is set, count == 0, and the last committed packet was exactly `MAX_PKT` bytes, IDLE → REQ with `pkt_len` = 0.
  - PUT then goes directly to DONE, sending a zero-length packet, and `flush_pend` is cleared.
- `USB_IN_EP_ZLP_EN` undefined:
  - `flush_pend` is cleared in IDLE when count == 0.
  - A zero-length packet is never generated.

## Test plan
- Write 64 bytes 0x00..0x3F, grant and free always high → req, 64 consecutive puts with data 0x00..0x3F, one done pulse, req low; an `in_ep_acked` pulse then returns the block to IDLE.
- Write 10 bytes, then pulse `app_flush` → one packet of 10 puts, then done; `flush_pend` = 0.
- Write 128 bytes with no ack → `app_ready` = 0 at count 128; a 129th write is dropped; after 2 acks, 128 bytes are delivered in order.
- Toggle `in_ep_data_free` low for 3 cycles mid-packet → puts pause with no byte lost or duplicated; the packet total is 64.
- Write 64 bytes, flush, then ack → with `USB_IN_EP_ZLP_EN` defined, a second packet with 0 puts and one done pulse; without it, no second request.
- Assert `reset` low during PUT after 20 puts → all outputs at reset values in the same cycle; count = 0 after release.
